// File: rtl/nibble_serial_adder.sv
// rtl/nibble_serial_adder.sv - multi-precision adder streaming operands through one 4-bit carry-skip slice

// 4-bit carry-skip slice: ripple sum, with the carry-out bypassed when every bit propagates
module nibble_carry_skip_slice (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       c_i,
  output logic [3:0] s_o,
  output logic       c_o,
  output logic       p_o
);

  logic [3:0] prop;
  logic [3:0] gen;
  logic [4:0] rc;

  assign prop  = a_i ^ b_i;
  assign gen   = a_i & b_i;
  assign rc[0] = c_i;
  assign rc[1] = gen[0] | (prop[0] & rc[0]);
  assign rc[2] = gen[1] | (prop[1] & rc[1]);
  assign rc[3] = gen[2] | (prop[2] & rc[2]);
  assign rc[4] = gen[3] | (prop[3] & rc[3]);

  assign s_o = prop ^ rc[3:0];
  assign p_o = &prop;
  // When all four bits propagate the incoming carry passes straight through
  assign c_o = p_o ? c_i : rc[4];

endmodule

module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [WIDTH-1:0]               a,
  input  logic [WIDTH-1:0]               b,
  input  logic                           cin,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [WIDTH-1:0]               sum,
  output logic                           cout,
  output logic [$clog2(WIDTH/4+1)-1:0]   skip_cnt
);

  localparam int NIB = WIDTH / 4;
  localparam int SW  = $clog2(NIB + 1);

  generate
    if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
      $error("nibble_serial_adder: WIDTH must be a multiple of 4 and at least 4");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             carry_q, carry_d;
  logic [SW-1:0]    cnt_q, cnt_d;
  logic [SW-1:0]    skip_q, skip_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic [SW-1:0]    skip_out_q, skip_out_d;

  logic [3:0]       nib_s;
  logic             nib_c;
  logic             nib_p;
  logic [WIDTH+3:0] acc_ext;

  nibble_carry_skip_slice u_slice (
    .a_i (a_q[3:0]),
    .b_i (b_q[3:0]),
    .c_i (carry_q),
    .s_o (nib_s),
    .c_o (nib_c),
    .p_o (nib_p)
  );

  // New sum nibble enters at the MSB end so the LSB nibble lands at bit 0 after the last step
  assign acc_ext = {nib_s, acc_q};

  assign sum      = sum_q;
  assign cout     = cout_q;
  assign skip_cnt = skip_out_q;

  // Next-state logic and handshake outputs
  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    acc_d      = acc_q;
    carry_d    = carry_q;
    cnt_d      = cnt_q;
    skip_d     = skip_q;
    sum_d      = sum_q;
    cout_d     = cout_q;
    skip_out_d = skip_out_q;
    in_ready   = 1'b0;
    out_valid  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          cnt_d   = '0;
          skip_d  = '0;
          state_d = ST_ADD;
        end
      end
      ST_ADD: begin
        acc_d   = acc_ext[WIDTH+3:4];
        a_d     = a_q >> 4;
        b_d     = b_q >> 4;
        carry_d = nib_c;
        cnt_d   = cnt_q + SW'(1);
        skip_d  = skip_q + SW'(nib_p);
        if (cnt_q == SW'(NIB - 1)) begin
          // Results are published only once complete, so outputs never show partial sums
          sum_d      = acc_ext[WIDTH+3:4];
          cout_d     = nib_c;
          skip_out_d = skip_q + SW'(nib_p);
          state_d    = ST_DONE;
        end
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      acc_q      <= '0;
      carry_q    <= 1'b0;
      cnt_q      <= '0;
      skip_q     <= '0;
      sum_q      <= '0;
      cout_q     <= 1'b0;
      skip_out_q <= '0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      acc_q      <= acc_d;
      carry_q    <= carry_d;
      cnt_q      <= cnt_d;
      skip_q     <= skip_d;
      sum_q      <= sum_d;
      cout_q     <= cout_d;
      skip_out_q <= skip_out_d;
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb/tb_nibble_serial_adder.sv - scoreboard bench for nibble_serial_adder

module tb_nibble_serial_adder;

  localparam int WIDTH = 16;
  localparam int SW    = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic [SW-1:0]    skip_cnt;

  typedef struct {
    logic [WIDTH-1:0] s;
    logic             c;
    logic [SW-1:0]    k;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   n_acc = 0;

  nibble_serial_adder #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .skip_cnt  (skip_cnt)
  );

  always #5 clk = ~clk;

  function automatic exp_t ref_model(logic [WIDTH-1:0] x, logic [WIDTH-1:0] y, logic ci);
    exp_t e;
    logic [WIDTH:0] t;
    logic [3:0] xn, yn;
    t   = {1'b0, x} + {1'b0, y} + (WIDTH+1)'(ci);
    e.s = t[WIDTH-1:0];
    e.c = t[WIDTH];
    e.k = '0;
    for (int i = 0; i < WIDTH/4; i++) begin
      xn = x[4*i +: 4];
      yn = y[4*i +: 4];
      if ((xn ^ yn) == 4'hF) e.k = e.k + 1'b1;
    end
    return e;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard push: an operand set is accepted on the coming edge
  always @(negedge clk) begin
    if (!rst && in_valid && in_ready) begin
      sb.push_back(ref_model(a, b, cin));
      n_acc++;
    end
  end

  // Monitor: a result is taken on the coming edge
  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_result", {15'd0, sum, cout}, 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        chk("result", {12'd0, sum, cout, skip_cnt}, {12'd0, e.s, e.c, e.k});
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 30) begin
      step();
      n++;
    end
    if (!in_ready) chk("in_ready_timeout", 32'(in_ready), 32'd1);
  endtask

  task automatic run_op(logic [WIDTH-1:0] xa, logic [WIDTH-1:0] xb, logic xc,
                        logic [WIDTH-1:0] es, logic ec, logic [SW-1:0] ek, string name);
    int n = 0;
    wait_ready();
    in_valid = 1'b1;
    a = xa; b = xb; cin = xc;
    step();
    in_valid = 1'b0;
    while (!out_valid && n < 30) begin
      step();
      n++;
    end
    chk({name, "_valid"}, 32'(out_valid), 32'd1);
    chk({name, "_sum"}, 32'(sum), 32'(es));
    chk({name, "_cout"}, 32'(cout), 32'(ec));
    chk({name, "_skip"}, 32'(skip_cnt), 32'(ek));
  endtask

  initial begin
    int lat;
    int cyc;
    int base;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_skip", 32'(skip_cnt), 32'd0);
    rst = 1'b0;
    step();

    // Test 1 with latency measurement
    in_valid = 1'b1; a = 16'h0000; b = 16'h0000; cin = 1'b0;
    step();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
    chk("t1_latency", 32'(lat), 32'd4);
    chk("t1_sum", 32'(sum), 32'h0000);
    chk("t1_cout", 32'(cout), 32'd0);
    chk("t1_skip", 32'(skip_cnt), 32'd0);
    step();

    run_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 3'd3, "t2");
    step();
    run_op(16'hF0F0, 16'h0F0F, 1'b1, 16'h0000, 1'b1, 3'd4, "t4");
    step();

    // Test 3 followed by backpressure with ignored in_valid pulses
    out_ready = 1'b0;
    run_op(16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 3'd0, "t3");
    for (int i = 0; i < 10; i++) begin
      in_valid = (i % 2 == 0);
      a = 16'hAAAA; b = 16'h5555; cin = 1'b1;
      step();
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_sum", 32'(sum), 32'h5556);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    chk("bp_release_in_ready", 32'(in_ready), 32'd1);
    chk("bp_release_out_valid", 32'(out_valid), 32'd0);
    repeat (3) step();
    chk("bp_no_phantom_op", 32'(out_valid), 32'd0);
    chk("bp_sb_empty", 32'(sb.size()), 32'd0);

    // Test 6: reset during the second ADD cycle
    wait_ready();
    in_valid = 1'b1; a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    rst = 1'b1;
    #1;
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_sum", 32'(sum), 32'd0);
    chk("abort_cout", 32'(cout), 32'd0);
    chk("abort_skip", 32'(skip_cnt), 32'd0);
    if (sb.size() > 0) void'(sb.pop_back());
    step();
    rst = 1'b0;
    step();
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    run_op(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 3'd0, "t6");
    step();

    // Random traffic with random valid/ready
    base = n_acc;
    cyc = 0;
    while (n_acc < base + 1000 && cyc < 40000) begin
      in_valid  = 1'($urandom_range(0, 1));
      a         = 16'($urandom);
      b         = 16'($urandom);
      cin       = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      step();
      cyc++;
    end
    in_valid = 1'b0;
    chk("random_ops_accepted", 32'(n_acc - base), 32'd1000);
    out_ready = 1'b1;
    cyc = 0;
    while (sb.size() != 0 && cyc < 100) begin
      step();
      cyc++;
    end
    chk("drain_sb_empty", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
